// File: rtl/mux_arb_pkg.sv
// Shared types and sizing helpers for the round-robin mux arbiter.
package mux_arb_pkg;

   localparam int BEAT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arbState_e;

   // Select width for n requesters; never narrower than one bit.
   function automatic int selW(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotate-priority picker: first asserted request at or after the pointer, wrapping modulo NUM_REQ.
module mux_rr_pick
   import mux_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int SEL_W = selW(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               any,
   output logic [SEL_W-1:0]   index
);

   logic [SEL_W-1:0] cand;

   // Scan from the farthest offset down so the nearest match overwrites earlier ones.
   // NUM_REQ is a power of two, so the SEL_W-bit add wraps naturally.
   always_comb begin
      any   = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            any   = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter driving a shared N-to-1 lane mux with a valid/ready output port.
//
// state | meaning
// IDLE  | no grant; pick next requester from the rr pointer
// BUSY  | one requester granted; beats flow while inReq[outSel] stays high
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 4,
   parameter int MAX_BURST = 8,
   localparam int SEL_W = selW(NUM_REQ)
) (
   input  logic                      inClk,
   input  logic                      inRstN,
   input  logic [NUM_REQ-1:0]        inReq,
   input  logic [NUM_REQ-1:0]        inLast,
   input  logic [NUM_REQ*DATA_W-1:0] inData,
   input  logic                      inReady,
   output logic [NUM_REQ-1:0]        outGrant,
   output logic [SEL_W-1:0]          outSel,
   output logic [DATA_W-1:0]         outData,
   output logic                      outValid
);

   arbState_e          stateQ, stateD;
   logic [NUM_REQ-1:0] grantQ, grantD;
   logic [SEL_W-1:0]   selQ, selD;
   logic [SEL_W-1:0]   ptrQ, ptrD;
   logic [BEAT_W-1:0]  beatQ, beatD;

   logic               pickAny;
   logic [SEL_W-1:0]   pickIdx;
   logic               accept;
   logic               lastBeat;

   mux_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) uPick (
      .req   (inReq),
      .ptr   (ptrQ),
      .any   (pickAny),
      .index (pickIdx)
   );

   assign outValid = (stateQ == BUSY) && inReq[selQ];
   assign accept   = outValid && inReady;
   assign lastBeat = inLast[selQ] || (beatQ == BEAT_W'(MAX_BURST - 1));

   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         stateQ <= IDLE;
         grantQ <= '0;
         selQ   <= '0;
         ptrQ   <= '0;
         beatQ  <= '0;
      end else begin
         stateQ <= stateD;
         grantQ <= grantD;
         selQ   <= selD;
         ptrQ   <= ptrD;
         beatQ  <= beatD;
      end
   end

   always_comb begin
      stateD = stateQ;
      grantD = grantQ;
      selD   = selQ;
      ptrD   = ptrQ;
      beatD  = beatQ;
      unique case (stateQ)
         IDLE: begin
            if (pickAny) begin
               stateD = BUSY;
               grantD = NUM_REQ'(1) << pickIdx;
               selD   = pickIdx;
               beatD  = '0;
            end
         end
         BUSY: begin
            // A dropped request abandons the burst; otherwise only accepted beats advance it.
            if (!inReq[selQ] || (accept && lastBeat)) begin
               stateD = IDLE;
               grantD = '0;
               ptrD   = selQ + SEL_W'(1);
               beatD  = '0;
            end else if (accept) begin
               beatD = beatQ + BEAT_W'(1);
            end
         end
         default: begin
            stateD = IDLE;
            grantD = '0;
         end
      endcase
   end

   assign outGrant = grantQ;
   assign outSel   = selQ;
   assign outData  = inData[int'(selQ) * DATA_W +: DATA_W];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected beats are queued by the stimulus and checked by a monitor.
module tb_mux_rr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 4;
   localparam int MAX_BURST = 8;
   localparam int SEL_W     = 2;

   logic                      inClk = 1'b0;
   logic                      inRstN;
   logic [NUM_REQ-1:0]        inReq;
   logic [NUM_REQ-1:0]        inLast;
   logic [NUM_REQ*DATA_W-1:0] inData;
   logic                      inReady;
   logic [NUM_REQ-1:0]        outGrant;
   logic [SEL_W-1:0]          outSel;
   logic [DATA_W-1:0]         outData;
   logic                      outValid;

   typedef struct {
      int sel;
      int data;
   } beat_t;

   beat_t expQ[$];
   int    checks = 0;
   int    errors = 0;

   mux_rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .inClk    (inClk),
      .inRstN   (inRstN),
      .inReq    (inReq),
      .inLast   (inLast),
      .inData   (inData),
      .inReady  (inReady),
      .outGrant (outGrant),
      .outSel   (outSel),
      .outData  (outData),
      .outValid (outValid)
   );

   always #5 inClk = ~inClk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge inClk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: act=0x%0h exp=0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic setLane(input int i, input logic [DATA_W-1:0] v);
      inData[i*DATA_W +: DATA_W] = v;
   endtask

   task automatic pushBeat(input int s, input int d);
      beat_t b;
      b.sel  = s;
      b.data = d;
      expQ.push_back(b);
   endtask

   task automatic doReset();
      inRstN  = 1'b0;
      inReq   = '0;
      inLast  = '0;
      inReady = 1'b0;
      step();
      step();
      inRstN = 1'b1;
   endtask

   // Monitor: every accepted beat must match the head of the expected queue.
   always @(negedge inClk) begin
      if (inRstN && outValid && inReady) begin
         beat_t b;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: act sel=%0d data=0x%0h exp=none @%0t", outSel, outData, $time);
         end else begin
            b = expQ.pop_front();
            if (int'(outSel) != b.sel || int'(outData) != b.data) begin
               errors++;
               $display("FAIL beat: act sel=%0d data=0x%0h exp sel=%0d data=0x%0h @%0t",
                        outSel, outData, b.sel, b.data, $time);
            end
         end
      end
   end

   initial begin
      inData = '0;
      setLane(0, 4'h3);
      setLane(1, 4'h9);
      setLane(2, 4'hA);
      setLane(3, 4'hC);
      doReset();
      chk("reset_grant", int'(outGrant), 0);
      chk("reset_sel", int'(outSel), 0);
      chk("reset_valid", int'(outValid), 0);

      // 1: reset mid-burst
      inReq   = 4'b0100;
      inReady = 1'b1;
      step();
      chk("t1_grant", int'(outGrant), 4'b0100);
      chk("t1_sel", int'(outSel), 2);
      chk("t1_valid", int'(outValid), 1);
      for (int b = 0; b < 3; b++) begin
         pushBeat(2, 4'hA);
         step();
      end
      inRstN  = 1'b0;
      inReady = 1'b0;
      step();
      chk("t1_rst_grant", int'(outGrant), 0);
      chk("t1_rst_valid", int'(outValid), 0);
      chk("t1_rst_sel", int'(outSel), 0);
      inRstN = 1'b1;
      inReq  = 4'b0101;
      step();
      chk("t1_regrant", int'(outGrant), 4'b0001);
      inReq = '0;
      step();
      chk("t1_abandon_idle", int'(outGrant), 0);

      // 2: single requester with last on 4th beat
      inReq   = 4'b0010;
      inReady = 1'b1;
      step();
      chk("t2_grant", int'(outGrant), 4'b0010);
      chk("t2_sel", int'(outSel), 1);
      for (int b = 1; b <= 4; b++) begin
         setLane(1, DATA_W'(b));
         inLast = (b == 4) ? 4'b0010 : 4'b0000;
         pushBeat(1, b);
         step();
      end
      inLast = '0;
      chk("t2_release", int'(outGrant), 0);
      chk("t2_idle_valid", int'(outValid), 0);
      step();
      chk("t2_regrant", int'(outGrant), 4'b0010);
      inReq = '0;
      step();
      setLane(1, 4'h9);

      // 3: round-robin with last always set
      doReset();
      inReq   = 4'b1111;
      inLast  = 4'b1111;
      inReady = 1'b1;
      begin
         int order[5] = '{0, 1, 2, 3, 0};
         int lane[4]  = '{4'h3, 4'h9, 4'hA, 4'hC};
         foreach (order[n]) begin
            step();
            chk("t3_grant", int'(outGrant), 1 << order[n]);
            chk("t3_sel", int'(outSel), order[n]);
            pushBeat(order[n], lane[order[n]]);
            step();
            chk("t3_gap", int'(outGrant), 0);
         end
      end
      inReq  = '0;
      inLast = '0;

      // 4: MAX_BURST cap (pointer is 1 here)
      inReq = 4'b1000;
      step();
      chk("t4_grant", int'(outGrant), 4'b1000);
      for (int b = 0; b < MAX_BURST; b++) begin
         pushBeat(3, 4'hC);
         step();
         if (b < MAX_BURST - 1) chk("t4_hold", int'(outGrant), 4'b1000);
         else                   chk("t4_release", int'(outGrant), 0);
      end
      inReq = 4'b1001;
      step();
      chk("t4_ptr_wrap", int'(outGrant), 4'b0001);
      inReq = '0;
      step();

      // 5: backpressure mid-burst (pointer is 1 here)
      inReq = 4'b0001;
      step();
      chk("t5_grant", int'(outGrant), 4'b0001);
      pushBeat(0, 4'h3);
      step();
      inReady = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("t5_stall_valid", int'(outValid), 1);
         chk("t5_stall_data", int'(outData), 4'h3);
         step();
      end
      chk("t5_stall_grant", int'(outGrant), 4'b0001);
      inReady = 1'b1;
      for (int b = 0; b < MAX_BURST - 1; b++) begin
         pushBeat(0, 4'h3);
         step();
         if (b < MAX_BURST - 2) chk("t5_hold", int'(outGrant), 4'b0001);
         else                   chk("t5_release", int'(outGrant), 0);
      end
      inReq = '0;
      step();

      // 6: abandon (pointer is 1 here)
      inReq = 4'b0011;
      step();
      chk("t6_grant", int'(outGrant), 4'b0010);
      for (int b = 0; b < 2; b++) begin
         pushBeat(1, 4'h9);
         step();
      end
      inReq = 4'b0101;
      #1;
      chk("t6_abandon_valid", int'(outValid), 0);
      step();
      chk("t6_release", int'(outGrant), 0);
      step();
      chk("t6_next_grant", int'(outGrant), 4'b0100);
      inReq = '0;
      step();
      step();

      chk("beats_pending", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one N-to-1 data mux between NUM_REQ requesters. It grants one requester at a time for a burst of beats and drives the mux select. It moves the selected lane to a single downstream port with a valid/ready handshake. It sits in front of the shared baseband datapath in the Zigbee TX chain.

Parameters:
NUM_REQ, 4, number of requesters; power of two, 2..8.
DATA_W, 4, width of each requester lane and of outData.
MAX_BURST, 8, maximum accepted beats per grant; range 1..255.

Ports:
inClk  input  1  clock, rising edge.
inRstN  input  1  synchronous active-low reset.
inReq  input  NUM_REQ  per-requester request; held high while the requester has data.
inLast  input  NUM_REQ  per-requester last-beat flag; sampled only on an accepted beat.
inData  input  NUM_REQ*DATA_W  packed lanes; lane i is inData[i*DATA_W +: DATA_W].
inReady  input  1  downstream ready.
outGrant  output  NUM_REQ  one-hot grant, registered; all zero when idle.
outSel  output  SEL_W = clog2(NUM_REQ)  mux select, registered; holds its last value when idle.
outData  output  DATA_W  lane outSel of inData, combinational.
outValid  output  1  equals (state == BUSY) && inReq[outSel].

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-low on inRstN, sampled at the rising edge of inClk.
- Reset values: state = IDLE, outGrant = 0, outSel = 0, rr pointer = 0, beat count = 0. outValid is therefore 0.
- Reset mid-burst: at the next edge with inRstN = 0, everything returns to reset values. The burst is abandoned with no completion, and the pointer returns to 0.
- State IDLE: if inReq != 0, pick the first i with inReq[i] = 1, searching pointer, pointer+1, ... modulo NUM_REQ.
  - Next edge: state = BUSY, outGrant = 1<<i, outSel = i, beat count = 0.
  - If inReq = 0, stay in IDLE.
- Latency: request to grant is 1 cycle. The first beat can be accepted in the cycle after the IDLE cycle.
- Accepted beat: outValid && inReady. Beat count increments only on an accepted beat. inReady low holds all state.
- Burst end, evaluated in BUSY (first match wins):
  - (a) Accepted beat with inLast[outSel] = 1.
  - (b) Accepted beat with beat count == MAX_BURST-1.
  - (c) inReq[outSel] = 0, which is an abandon; no beat is accepted that cycle.
- On burst end, at the next edge: state = IDLE, outGrant = 0, pointer = (outSel+1) mod NUM_REQ, beat count = 0.
- Gap between grants: one IDLE cycle always separates consecutive grants, including re-grant of the same requester.
- Requests arriving during BUSY are only considered in the following IDLE cycle. Non-granted inLast bits are ignored.
- Fairness: with all requesters continuously requesting, grant order is 0, 1, ..., NUM_REQ-1, 0, ...
- Beat count width: 8 bits. MAX_BURST = 1 ends the burst on every accepted beat.
- No X propagation: outData is a plain indexed part-select, and outSel is always in range.

Decomposition:
- Package mux_arb_pkg:
  - state enum {IDLE, BUSY};
  - SEL_W helper function (clog2);
  - beat count width constant BEAT_W = 8.
- Sub-module mux_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, pointer.
  - Outputs: any, index.
  - Its own unit bench covers all pointer values.
- Top-level content: the state register, counter and output mux.

Test Plan:
1. Reset mid-burst: grant req 2, accept 3 beats, drop inRstN for 1 cycle -> outGrant = 0, outValid = 0, pointer = 0. Then inReq = 4'b0101 -> grant req 0 next cycle.
2. Single requester with last: inReq = 4'b0010, lane1 = 0x1..0x4, inReady = 1, inLast[1] on the 4th beat -> outSel = 1, outData sequence 1, 2, 3, 4. outGrant = 0 on the following cycle, then re-granted after one IDLE cycle.
3. Round-robin: inReq = 4'b1111 held, inLast always 1 -> grant order 0, 1, 2, 3, 0, with exactly one IDLE cycle between grants.
4. MAX_BURST cap: req 3 holds, inLast = 0, MAX_BURST = 8 -> exactly 8 accepted beats, then release; pointer = 0.
5. Backpressure: inReady low for 5 cycles mid-burst -> outValid stays 1, outData stable, beat count frozen, no release.
6. Abandon: req 1 granted, inReq[1] drops after 2 beats -> outValid = 0 that cycle, release next edge, pointer = 2. A pending req 0 is granted only after req 2 and req 3 are checked.
